// File: rtl/tb_irq_claim_resp.sv
// tb_irq_claim_resp
// Interrupt responder that sits opposite the tb IRQ stimulus lines. Raw sources
// are latched into pending bits. The lowest enabled pending source is offered
// to the consumer on irq_o/irq_id_o. The consumer claims it and later completes
// it, each over a one-cycle req/ack pulse pair.
//
// Ports:
//   tb_clk, tb_rst      clock, asynchronous active-high reset
//   irq_src_i/irq_en_i  raw sources and per-source enables
//   irq_o/irq_id_o      registered interrupt and winner id (id = index+1, 0 = none)
//   claim_req_i         claim pulse; answered by claim_ack_o/claim_id_o
//   cmpl_req_i/cmpl_id_i completion pulse; answered by cmpl_ack_o
//   busy_o              high while a claimed interrupt is in service
//   claim_cnt_o         count of successful (non-zero id) claims, wraps
//   timeout_err_o       sticky claim watchdog error
//
// Optional feature: define TB_IRQ_CLAIM_TIMEOUT_EN to enable the claim watchdog.
// Without it timeout_err_o is tied low and CLAIMED waits forever.
module tb_irq_claim_resp #(
  parameter int                 IRQ_NUM     = 8,
  parameter int                 ID_W        = 5,
  parameter logic [IRQ_NUM-1:0] EDGE_MASK   = IRQ_NUM'('h0F),
  parameter int                 TIMEOUT_CYC = 1024
) (
  input  logic               tb_clk,
  input  logic               tb_rst,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  input  logic [IRQ_NUM-1:0] irq_en_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               claim_req_i,
  output logic               claim_ack_o,
  output logic [ID_W-1:0]    claim_id_o,
  input  logic               cmpl_req_i,
  input  logic [ID_W-1:0]    cmpl_id_i,
  output logic               cmpl_ack_o,
  output logic               busy_o,
  output logic [31:0]        claim_cnt_o,
  output logic               timeout_err_o
);

  typedef enum logic {IDLE, CLAIMED} state_e;

  state_e             state_q, state_d;
  logic [IRQ_NUM-1:0] src_q, pend_q, pend_d, svc_q, svc_d;
  logic [IRQ_NUM-1:0] pend_set, pend_clr, svc_set, svc_clr;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               claim_ack_q, claim_ack_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic               cmpl_ack_q, cmpl_ack_d;
  logic [ID_W-1:0]    claimed_q, claimed_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [IRQ_NUM-1:0] win_oh;
  logic               cmpl_hit;
  logic               to_fire;

  // Gateway: sources already in service cannot re-pend; such events are lost.
  assign pend_set = ((irq_src_i & ~src_q & EDGE_MASK) | (irq_src_i & ~EDGE_MASK)) & ~svc_q;

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_oh  = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pend_q[i] && irq_en_i[i]) begin
        win_vld   = 1'b1;
        win_id    = ID_W'(i + 1);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign cmpl_hit = cmpl_req_i && (cmpl_id_i == claimed_q);

  always_comb begin
    state_d     = state_q;
    pend_clr    = '0;
    svc_set     = '0;
    svc_clr     = '0;
    claim_ack_d = 1'b0;
    claim_id_d  = '0;
    cmpl_ack_d  = 1'b0;
    claimed_d   = claimed_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (claim_req_i) begin
          claim_ack_d = 1'b1;
          claim_id_d  = win_id;
          if (win_vld) begin
            pend_clr  = win_oh;
            svc_set   = win_oh;
            claimed_d = win_id;
            cnt_d     = cnt_q + 32'd1;
            state_d   = CLAIMED;
          end
        end
      end
      CLAIMED: begin
        // Only one source is ever in service, so leaving CLAIMED clears all.
        if (cmpl_hit) begin
          cmpl_ack_d = 1'b1;
          svc_clr    = '1;
          state_d    = IDLE;
        end else if (to_fire) begin
          svc_clr = '1;
          state_d = IDLE;
        end
        // No nesting: a claim while busy is always answered with id 0.
        if (claim_req_i) claim_ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over set so a still-high level source stays cleared after claim.
  assign pend_d   = (pend_q | pend_set) & ~pend_clr;
  assign svc_d    = (svc_q | svc_set) & ~svc_clr;
  assign irq_d    = (state_d == IDLE) && win_vld;
  assign irq_id_d = irq_d ? win_id : '0;

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pend_q      <= '0;
      svc_q       <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
      claim_ack_q <= 1'b0;
      claim_id_q  <= '0;
      cmpl_ack_q  <= 1'b0;
      claimed_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= irq_src_i;
      pend_q      <= pend_d;
      svc_q       <= svc_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
      claim_ack_q <= claim_ack_d;
      claim_id_q  <= claim_id_d;
      cmpl_ack_q  <= cmpl_ack_d;
      claimed_q   <= claimed_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef TB_IRQ_CLAIM_TIMEOUT_EN
  // Down-counter reloaded while idle, so it holds TIMEOUT_CYC-1 on entry to CLAIMED.
  logic [31:0] to_cnt_q;
  logic        to_err_q;

  assign to_fire = (state_q == CLAIMED) && (to_cnt_q == 32'd0);

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE)        to_cnt_q <= 32'(TIMEOUT_CYC - 1);
      else if (to_cnt_q != 32'd0) to_cnt_q <= to_cnt_q - 32'd1;
      if (to_fire && !cmpl_hit)   to_err_q <= 1'b1;
    end
  end

  assign timeout_err_o = to_err_q;
`else
  assign to_fire       = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign irq_o       = irq_q;
  assign irq_id_o    = irq_id_q;
  assign claim_ack_o = claim_ack_q;
  assign claim_id_o  = claim_id_q;
  assign cmpl_ack_o  = cmpl_ack_q;
  assign busy_o      = (state_q == CLAIMED);
  assign claim_cnt_o = cnt_q;

endmodule

// File: tb/tb_tb_irq_claim_resp.sv
// Bench for tb_irq_claim_resp. Claim responses are predicted into a queue when
// a claim is issued and compared when claim_ack_o appears.
module tb_tb_irq_claim_resp;
  localparam int IRQ_NUM = 8;
  localparam int ID_W    = 5;
`ifdef TB_IRQ_CLAIM_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic               tb_clk, tb_rst;
  logic [IRQ_NUM-1:0] irq_src_i, irq_en_i;
  logic               irq_o;
  logic [ID_W-1:0]    irq_id_o;
  logic               claim_req_i, claim_ack_o;
  logic [ID_W-1:0]    claim_id_o;
  logic               cmpl_req_i;
  logic [ID_W-1:0]    cmpl_id_i;
  logic               cmpl_ack_o, busy_o;
  logic [31:0]        claim_cnt_o;
  logic               timeout_err_o;

  tb_irq_claim_resp #(
    .IRQ_NUM(IRQ_NUM), .ID_W(ID_W), .EDGE_MASK(8'h0F), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .tb_clk(tb_clk), .tb_rst(tb_rst),
    .irq_src_i(irq_src_i), .irq_en_i(irq_en_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o),
    .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o), .claim_id_o(claim_id_o),
    .cmpl_req_i(cmpl_req_i), .cmpl_id_i(cmpl_id_i), .cmpl_ack_o(cmpl_ack_o),
    .busy_o(busy_o), .claim_cnt_o(claim_cnt_o), .timeout_err_o(timeout_err_o)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [ID_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_irq"},   32'(irq_o), 0);
    chk({tag, "_irqid"}, 32'(irq_id_o), 0);
    chk({tag, "_cack"},  32'(claim_ack_o), 0);
    chk({tag, "_cid"},   32'(claim_id_o), 0);
    chk({tag, "_mack"},  32'(cmpl_ack_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_cnt"},   claim_cnt_o, 0);
    chk({tag, "_terr"},  32'(timeout_err_o), 0);
  endtask

  task automatic do_claim(input logic [ID_W-1:0] exp_id);
    exp_q.push_back(exp_id);
    claim_req_i = 1'b1;
    tick();
    claim_req_i = 1'b0;
    chk("claim_ack", 32'(claim_ack_o), 1);
  endtask

  task automatic do_cmpl(input logic [ID_W-1:0] id, input logic exp_ack);
    cmpl_req_i = 1'b1;
    cmpl_id_i  = id;
    tick();
    cmpl_req_i = 1'b0;
    cmpl_id_i  = '0;
    chk("cmpl_ack", 32'(cmpl_ack_o), 32'(exp_ack));
  endtask

  // Scoreboard: every claim acknowledge must match the oldest prediction.
  always @(negedge tb_clk) begin
    if (!tb_rst && claim_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL claim_ack_unexpected observed id=0x%0h expected=no ack", claim_id_o);
      end else begin
        chk("claim_id", 32'(claim_id_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=sim still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tb_rst = 1'b1; irq_src_i = '0; irq_en_i = '1;
    claim_req_i = 1'b0; cmpl_req_i = 1'b0; cmpl_id_i = '0;
    repeat (3) tick();
    chk_idle_zero("reset");
    tb_rst = 1'b0;
    tick();

    // Edge source 2: irq two cycles after the edge
    irq_src_i[2] = 1'b1;
    tick();
    irq_src_i[2] = 1'b0;
    chk("t1_irq_early", 32'(irq_o), 0);
    tick();
    chk("t1_irq", 32'(irq_o), 1);
    chk("t1_irqid", 32'(irq_id_o), 3);
    do_claim(5'd3);
    chk("t1_irq_claimed", 32'(irq_o), 0);
    chk("t1_busy", 32'(busy_o), 1);
    chk("t1_cnt", claim_cnt_o, 1);
    tick();
    chk("t1_ack_pulse", 32'(claim_ack_o), 0);
    do_cmpl(5'd3, 1'b1);
    chk("t1_busy_done", 32'(busy_o), 0);
    chk("t1_irq_after", 32'(irq_o), 0);
    tick();
    chk("t1_mack_pulse", 32'(cmpl_ack_o), 0);
    chk("t1_irq_stays", 32'(irq_o), 0);

    // Sources 1 and 5 together: lowest index wins first
    irq_src_i[1] = 1'b1; irq_src_i[5] = 1'b1;
    tick();
    irq_src_i[1] = 1'b0; irq_src_i[5] = 1'b0;
    tick();
    chk("t2_irqid", 32'(irq_id_o), 2);
    do_claim(5'd2);
    do_cmpl(5'd2, 1'b1);
    chk("t2_next_irq", 32'(irq_o), 1);
    chk("t2_next_id", 32'(irq_id_o), 6);
    do_claim(5'd6);
    chk("t2_cnt", claim_cnt_o, 3);
    do_cmpl(5'd6, 1'b1);

    // Level source 6 held high re-pends only after completion
    irq_src_i[6] = 1'b1;
    tick();
    tick();
    chk("t3_irqid", 32'(irq_id_o), 7);
    do_claim(5'd7);
    tick();
    tick();
    chk("t3_irq_held", 32'(irq_o), 0);
    do_cmpl(5'd7, 1'b1);
    chk("t3_irq_at_ack", 32'(irq_o), 0);
    tick();
    chk("t3_irq_plus1", 32'(irq_o), 0);
    tick();
    chk("t3_irq_plus2", 32'(irq_o), 1);
    chk("t3_irqid_plus2", 32'(irq_id_o), 7);

    // Wrong-id completion, nested claim, simultaneous claim+completion
    do_claim(5'd7);
    irq_src_i[6] = 1'b0;
    do_cmpl(5'd3, 1'b0);
    chk("t4_busy_wrong", 32'(busy_o), 1);
    do_claim(5'd0);
    chk("t4_busy_nest", 32'(busy_o), 1);
    chk("t4_cnt_nest", claim_cnt_o, 5);
    exp_q.push_back(5'd0);
    claim_req_i = 1'b1; cmpl_req_i = 1'b1; cmpl_id_i = 5'd7;
    tick();
    claim_req_i = 1'b0; cmpl_req_i = 1'b0; cmpl_id_i = '0;
    chk("t4_both_cack", 32'(claim_ack_o), 1);
    chk("t4_both_mack", 32'(cmpl_ack_o), 1);
    chk("t4_both_busy", 32'(busy_o), 0);
    chk("t4_cnt", claim_cnt_o, 5);

    // Nothing pending, then only a disabled source pending
    do_claim(5'd0);
    chk("t5_busy_none", 32'(busy_o), 0);
    irq_en_i = 8'hEF;
    irq_src_i[4] = 1'b1;
    tick();
    irq_src_i[4] = 1'b0;
    tick();
    chk("t5_irq_disabled", 32'(irq_o), 0);
    do_claim(5'd0);
    chk("t5_busy_disabled", 32'(busy_o), 0);
    chk("t5_cnt", claim_cnt_o, 5);
    irq_en_i = '1;
    tick();
    chk("t5_irq_enabled", 32'(irq_o), 1);
    chk("t5_irqid_enabled", 32'(irq_id_o), 5);
    do_claim(5'd5);
    do_cmpl(5'd5, 1'b1);

    // Completion in IDLE is ignored
    do_cmpl(5'd5, 1'b0);

    // Edge arriving while its source is in service is dropped
    irq_src_i[0] = 1'b1;
    tick();
    irq_src_i[0] = 1'b0;
    tick();
    chk("t7_irqid", 32'(irq_id_o), 1);
    do_claim(5'd1);
    irq_src_i[0] = 1'b1;
    tick();
    irq_src_i[0] = 1'b0;
    tick();
    do_cmpl(5'd1, 1'b1);
    tick();
    tick();
    chk("t7_dropped", 32'(irq_o), 0);
    chk("t7_cnt", claim_cnt_o, 7);

    // Long stay in CLAIMED: watchdog trips only when enabled
    irq_src_i[3] = 1'b1;
    tick();
    irq_src_i[3] = 1'b0;
    tick();
    do_claim(5'd4);
`ifdef TB_IRQ_CLAIM_TIMEOUT_EN
    repeat (15) tick();
    chk("to_err_before", 32'(timeout_err_o), 0);
    chk("to_busy_before", 32'(busy_o), 1);
    tick();
    chk("to_err", 32'(timeout_err_o), 1);
    chk("to_busy", 32'(busy_o), 0);
    chk("to_no_mack", 32'(cmpl_ack_o), 0);
    tick();
    chk("to_err_sticky", 32'(timeout_err_o), 1);
`else
    repeat (20) tick();
    chk("wait_busy", 32'(busy_o), 1);
    chk("wait_err", 32'(timeout_err_o), 0);
    do_cmpl(5'd4, 1'b1);
`endif
    chk("cnt_final", claim_cnt_o, 8);

    // Reset in the middle of a claim: abort, no ack
    irq_src_i[2] = 1'b1;
    tick();
    irq_src_i[2] = 1'b0;
    tick();
    chk("rst_pre_irq", 32'(irq_o), 1);
    claim_req_i = 1'b1;
    tb_rst = 1'b1;
    #1;
    chk_idle_zero("rst_async");
    tick();
    claim_req_i = 1'b0;
    chk_idle_zero("rst_held");
    tb_rst = 1'b0;
    tick();
    chk("rst_after_irq", 32'(irq_o), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
